// File: rtl/operand_loader.sv
// operand_loader: captures two switch operands on load presses and toggles add/sub on op presses for the LED mux stage.
// Build option: define DEBOUNCE_EN to debounce both buttons for DB_CYCLES stable cycles; undefined uses synced levels directly.
module operand_loader #(
  parameter int DB_CYCLES = 1_000_000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] sw,
  input  logic       btn_load,
  input  logic       btn_op,
  output logic [3:0] input_a,
  output logic [3:0] input_b,
  output logic       mux_sel,
  output logic       en,
  output logic [1:0] state_led
);
  typedef enum logic [1:0] {S_IDLE = 2'b00, S_HAVE_A = 2'b01, S_READY = 2'b10} state_t;
  state_t state;
  logic [3:0] sw_s1, sw_sync;
  logic [1:0] btn_s1, btn_sync, acc, acc_q, pulse;
  always_ff @(posedge clk)
    if (rst) begin
      sw_s1    <= '0;
      sw_sync  <= '0;
      btn_s1   <= '0;
      btn_sync <= '0;
      acc_q    <= '0;
    end else begin
      sw_s1    <= sw;
      sw_sync  <= sw_s1;
      btn_s1   <= {btn_op, btn_load};
      btn_sync <= btn_s1;
      acc_q    <= acc;
    end
`ifdef DEBOUNCE_EN
  localparam int CW = $clog2(DB_CYCLES + 1);
  for (genvar i = 0; i < 2; i++) begin : g_db
    logic [CW-1:0] cnt;
    logic lvl;
    always_ff @(posedge clk)
      if (rst) begin
        cnt <= '0;
        lvl <= 1'b0;
      end else if (btn_sync[i] == lvl) cnt <= '0;
      else if (cnt == CW'(DB_CYCLES - 1)) begin
        lvl <= ~lvl;
        cnt <= '0;
      end else cnt <= cnt + 1'b1;
    assign acc[i] = lvl;
  end
`else
  assign acc = btn_sync;
`endif
  // bit 0 = load, bit 1 = op
  assign pulse     = acc & ~acc_q;
  assign state_led = state;
  always_ff @(posedge clk)
    if (rst) begin
      state   <= S_IDLE;
      input_a <= '0;
      input_b <= '0;
      mux_sel <= 1'b0;
      en      <= 1'b0;
    end else begin
      if (pulse[1]) mux_sel <= ~mux_sel;
      case (state)
        S_IDLE: if (pulse[0]) begin
          input_a <= sw_sync;
          state   <= S_HAVE_A;
        end
        S_HAVE_A: if (pulse[0]) begin
          input_b <= sw_sync;
          en      <= 1'b1;
          state   <= S_READY;
        end
        S_READY: if (pulse[0]) begin
          input_a <= sw_sync;
          en      <= 1'b0;
          state   <= S_HAVE_A;
        end
        default: begin
          state <= S_IDLE;
          en    <= 1'b0;
        end
      endcase
    end
endmodule

// File: tb/tb_operand_loader.sv
// tb_operand_loader: directed and randomized press sequences checked against a transaction-level operand entry model.
module tb_operand_loader;
  localparam int DB = 4;
`ifdef DEBOUNCE_EN
  localparam bit DBE = 1'b1;
`else
  localparam bit DBE = 1'b0;
`endif
  logic clk = 1'b0, rst = 1'b1, btn_load = 1'b0, btn_op = 1'b0;
  logic [3:0] sw = '0, input_a, input_b;
  logic mux_sel, en;
  logic [1:0] state_led;
  int n_tests = 0, n_fail = 0;
  logic [3:0] m_a = '0, m_b = '0;
  logic m_sel = 1'b0;
  logic [1:0] m_st = 2'd0;
  operand_loader #(.DB_CYCLES(DB)) dut (
    .clk(clk), .rst(rst), .sw(sw), .btn_load(btn_load), .btn_op(btn_op),
    .input_a(input_a), .input_b(input_b), .mux_sel(mux_sel), .en(en), .state_led(state_led)
  );
  always #5 clk = ~clk;
  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask
  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask
  task automatic check_all(input string tag);
    chk({tag, ".input_a"}, 8'(input_a), 8'(m_a));
    chk({tag, ".input_b"}, 8'(input_b), 8'(m_b));
    chk({tag, ".mux_sel"}, 8'(mux_sel), 8'(m_sel));
    chk({tag, ".en"}, 8'(en), 8'(m_st == 2'd2));
    chk({tag, ".state_led"}, 8'(state_led), 8'(m_st));
  endtask
  task automatic model_reset();
    m_a = '0; m_b = '0; m_sel = 1'b0; m_st = 2'd0;
  endtask
  // One accepted press of each requested button, seen by the entry sequence
  task automatic model_apply(input logic ld, input logic op, input logic [3:0] v);
    if (op) m_sel = ~m_sel;
    if (ld) begin
      if (m_st == 2'd1) begin m_b = v; m_st = 2'd2; end
      else begin m_a = v; m_st = 2'd1; end
    end
  endtask
  task automatic press(input logic ld, input logic op, input logic [3:0] v);
    sw = v; btn_load = ld; btn_op = op;
    tick(DB + 3 + int'($urandom_range(0, 4)));
    btn_load = 1'b0; btn_op = 1'b0;
    tick(DB + 4);
    model_apply(ld, op, v);
  endtask
  initial begin
    int lat, r, w;
    logic [3:0] v;
    tick(2);
    rst = 1'b0;
    check_all("reset");
    press(1'b1, 1'b0, 4'h3);
    check_all("entry_a");
    sw = 4'h5; btn_load = 1'b1; lat = 0;
    for (int k = 1; k <= 20 && lat == 0; k++) begin
      tick(1);
      if (en === 1'b1) lat = k;
    end
    chk("latency", 8'(lat), DBE ? 8'd7 : 8'd3);
    tick(4);
    btn_load = 1'b0;
    tick(DB + 4);
    model_apply(1'b1, 1'b0, 4'h5);
    check_all("entry_b");
`ifdef DEBOUNCE_EN
    for (int k = 0; k < 6; k++) begin
      btn_load = ~btn_load;
      tick(2);
    end
    btn_load = 1'b0;
    tick(DB + 4);
    check_all("bounce");
`endif
    press(1'b0, 1'b1, 4'h5);
    check_all("op1");
    press(1'b0, 1'b1, 4'h5);
    check_all("op2");
    press(1'b1, 1'b0, 4'h9);
    check_all("reentry");
    sw = 4'hc; btn_load = 1'b1;
    tick(3);
    rst = 1'b1;
    tick(1);
    rst = 1'b0;
    model_reset();
    check_all("rst_mid");
    tick(10);
    model_apply(1'b1, 1'b0, 4'hc);
    check_all("rst_held");
    btn_load = 1'b0;
    tick(DB + 4);
    for (int it = 0; it < 30; it++) begin
      r = int'($urandom_range(0, DBE ? 4 : 3));
      v = 4'($urandom);
      if (r == 0) press(1'b1, 1'b0, v);
      else if (r == 1) press(1'b0, 1'b1, v);
      else if (r == 2) press(1'b1, 1'b1, v);
      else if (r == 3) begin
        sw = v;
        tick(6);
      end else begin
        w = int'($urandom_range(1, DB - 1));
        sw = v; btn_load = $urandom_range(0, 1) == 1; btn_op = ~btn_load;
        tick(w);
        btn_load = 1'b0; btn_op = 1'b0;
        tick(DB + 4);
      end
      check_all("random");
    end
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
